// File: rtl/commit_trace_pkg.sv
// Shared types and constants for the commit trace buffer.
// This package defines the trace record layout and the breakpoint cause code.
package commit_trace_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned VLEN = 64;

   // An exception with this cause, taken while in debug mode, is not traced.
   localparam logic [XLEN-1:0] BREAKPOINT_CAUSE = 64'd3;

   typedef struct packed {
      logic [15:0]      seq;
      logic             lost;
      logic             is_exc;
      logic [1:0]       priv;
      logic [VLEN-1:0]  pc;
      logic [31:0]      instr;
      logic [4:0]       rd;
      logic [XLEN-1:0]  wdata;
      logic             we_gpr;
      logic             we_fpr;
      logic [XLEN-1:0]  cause;
      logic [XLEN-1:0]  tval;
   } trace_rec_t;

endpackage

// File: rtl/commit_trace_fifo.sv
// Circular buffer with multi-push and single-pop.
// Up to NPush compacted records are written per cycle. One record is popped per cycle.
// The head record is read from registered storage. The head reads as zero while the buffer is empty.
module commit_trace_fifo
   import commit_trace_pkg::*;
#(
   parameter int unsigned NPush = 3,
   parameter int unsigned Depth = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [$clog2(Depth):0]     i_push_cnt,
   input  trace_rec_t [NPush-1:0]     i_push_rec,
   input  logic                       i_pop,
   output logic [$clog2(Depth):0]     o_count,
   output logic [$clog2(Depth):0]     o_free,
   output trace_rec_t                 o_head
);

   localparam int unsigned PW = $clog2(Depth);
   localparam int unsigned CW = $clog2(Depth) + 1;

   trace_rec_t          r_mem [Depth];
   logic [PW-1:0]       r_wr_ptr;
   logic [PW-1:0]       r_rd_ptr;
   logic [CW-1:0]       r_count;
   logic [CW-1:0]       w_free;
   logic [CW-1:0]       w_push_eff;
   logic                w_pop;

   // Space and effective push/pop amounts; pushes never exceed the space free at cycle start.
   always_comb begin
      w_free = CW'(Depth) - r_count;
      if (i_push_cnt > w_free) begin
         w_push_eff = w_free;
      end else begin
         w_push_eff = i_push_cnt;
      end
      w_pop = i_pop & (r_count != {CW{1'b0}});
   end

   // Pointer, occupancy and storage update; pointers wrap naturally modulo Depth.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         for (int j = 0; j < int'(NPush); j++) begin
            if (CW'(j) < w_push_eff) begin
               r_mem[r_wr_ptr + PW'(j)] <= i_push_rec[j];
            end
         end
         r_wr_ptr <= r_wr_ptr + w_push_eff[PW-1:0];
         r_rd_ptr <= r_rd_ptr + PW'(w_pop);
         r_count  <= r_count + w_push_eff - CW'(w_pop);
      end
   end

   // Head record, forced to zero while empty so stale entries never leak out.
   always_comb begin
      if (r_count != {CW{1'b0}}) begin
         o_head = r_mem[r_rd_ptr];
      end else begin
         o_head = '0;
      end
   end

   assign o_count = r_count;
   assign o_free  = w_free;

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures commit-stage retire events and drains them one record per cycle.
// Candidates are compacted in the order port0, exception, port1..N-1. Each candidate is tagged with
// a running sequence number. Candidates that do not fit are counted as lost, and commit is not stalled.
module commit_trace_buffer
   import commit_trace_pkg::*;
#(
   parameter int unsigned NrCommitPorts = 2,
   parameter int unsigned Depth         = 16
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  trace_en_i,
   input  logic [NrCommitPorts-1:0]              commit_ack_i,
   input  logic [NrCommitPorts-1:0]              commit_drop_i,
   input  logic [NrCommitPorts-1:0][VLEN-1:0]    commit_pc_i,
   input  logic [NrCommitPorts-1:0][31:0]        commit_instr_i,
   input  logic [NrCommitPorts-1:0][4:0]         commit_rd_i,
   input  logic [NrCommitPorts-1:0][XLEN-1:0]    commit_wdata_i,
   input  logic [NrCommitPorts-1:0]              commit_we_gpr_i,
   input  logic [NrCommitPorts-1:0]              commit_we_fpr_i,
   input  logic [1:0]                            priv_lvl_i,
   input  logic                                  debug_mode_i,
   input  logic                                  ex_valid_i,
   input  logic [XLEN-1:0]                       ex_cause_i,
   input  logic [XLEN-1:0]                       ex_tval_i,
   output logic                                  out_valid_o,
   input  logic                                  out_ready_i,
   output trace_rec_t                            out_rec_o,
   output logic [31:0]                           drop_cnt_o,
   output logic                                  overflow_o
);

   localparam int unsigned NCand = NrCommitPorts + 1;
   localparam int unsigned CW    = $clog2(Depth) + 1;

   trace_rec_t [NCand-1:0]          w_cand_rec;
   logic       [NCand-1:0]          w_cand_vld;
   logic       [NCand-1:0][CW-1:0]  w_rank;
   logic       [CW-1:0]             w_n_cand;
   trace_rec_t [NCand-1:0]          w_comp_rec;
   trace_rec_t [NCand-1:0]          w_push_rec;
   logic       [CW-1:0]             w_n_push;
   logic       [CW-1:0]             w_n_lost;
   logic       [CW-1:0]             w_count;
   logic       [CW-1:0]             w_free;
   logic       [32:0]               w_drop_sum;
   logic                            w_pop;

   logic       [15:0]               r_seq;
   logic                            r_lost_pending;
   logic       [31:0]               r_drop_cnt;
   logic                            r_overflow;

   function automatic trace_rec_t f_instr_rec(
      input logic [VLEN-1:0] pc,
      input logic [31:0]     instr,
      input logic [4:0]      rd,
      input logic [XLEN-1:0] wdata,
      input logic            we_gpr,
      input logic            we_fpr,
      input logic [1:0]      priv
   );
      trace_rec_t rec;
      rec        = '0;
      rec.pc     = pc;
      rec.instr  = instr;
      rec.rd     = rd;
      rec.wdata  = wdata;
      rec.we_gpr = we_gpr;
      rec.we_fpr = we_fpr;
      rec.priv   = priv;
      return rec;
   endfunction

   function automatic trace_rec_t f_exc_rec(
      input logic [VLEN-1:0] pc,
      input logic [XLEN-1:0] cause,
      input logic [XLEN-1:0] tval
   );
      trace_rec_t rec;
      rec        = '0;
      rec.is_exc = 1'b1;
      rec.pc     = pc;
      rec.cause  = cause;
      rec.tval   = tval;
      return rec;
   endfunction

   // Build the candidate list in trace order: port0, exception, then the remaining ports.
   always_comb begin
      w_cand_vld    = '0;
      w_cand_rec[0] = f_instr_rec(commit_pc_i[0], commit_instr_i[0], commit_rd_i[0],
                                  commit_wdata_i[0], commit_we_gpr_i[0], commit_we_fpr_i[0],
                                  priv_lvl_i);
      w_cand_rec[1] = f_exc_rec(commit_pc_i[0], ex_cause_i, ex_tval_i);
      for (int i = 1; i < int'(NrCommitPorts); i++) begin
         w_cand_rec[i+1] = f_instr_rec(commit_pc_i[i], commit_instr_i[i], commit_rd_i[i],
                                       commit_wdata_i[i], commit_we_gpr_i[i],
                                       commit_we_fpr_i[i], priv_lvl_i);
      end
      if (trace_en_i) begin
         w_cand_vld[0] = commit_ack_i[0] & ~commit_drop_i[0];
         w_cand_vld[1] = ex_valid_i & ~(debug_mode_i & (ex_cause_i == BREAKPOINT_CAUSE));
         for (int i = 1; i < int'(NrCommitPorts); i++) begin
            w_cand_vld[i+1] = commit_ack_i[i] & ~commit_drop_i[i];
         end
      end else begin
         w_cand_vld = '0;
      end
   end

   // Rank each valid candidate by its position among the valid ones, and count them.
   always_comb begin
      w_n_cand = '0;
      for (int i = 0; i < int'(NCand); i++) begin
         w_rank[i] = w_n_cand;
         if (w_cand_vld[i]) begin
            w_n_cand = w_n_cand + CW'(1);
         end else begin
            w_n_cand = w_n_cand;
         end
      end
   end

   // Compact the valid candidates into consecutive push slots.
   always_comb begin
      for (int j = 0; j < int'(NCand); j++) begin
         w_comp_rec[j] = '0;
         for (int i = 0; i < int'(NCand); i++) begin
            if (w_cand_vld[i] && (w_rank[i] == CW'(j))) begin
               w_comp_rec[j] = w_cand_rec[i];
            end else begin
               w_comp_rec[j] = w_comp_rec[j];
            end
         end
      end
   end

   // Clip to the free space and tag the pushed records with seq and the lost marker.
   always_comb begin
      if (w_n_cand < w_free) begin
         w_n_push = w_n_cand;
      end else begin
         w_n_push = w_free;
      end
      w_n_lost   = w_n_cand - w_n_push;
      w_drop_sum = {1'b0, r_drop_cnt} + 33'(w_n_lost);
      for (int j = 0; j < int'(NCand); j++) begin
         w_push_rec[j]      = w_comp_rec[j];
         w_push_rec[j].seq  = r_seq + 16'(j);
         w_push_rec[j].lost = (j == 0) ? r_lost_pending : 1'b0;
      end
      w_pop = out_valid_o & out_ready_i;
   end

   // Sequence counter, pending-loss flag and saturating loss accounting.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_seq          <= 16'd0;
         r_lost_pending <= 1'b0;
         r_drop_cnt     <= 32'd0;
         r_overflow     <= 1'b0;
      end else begin
         r_seq <= r_seq + 16'(w_n_push);
         if (w_n_lost != {CW{1'b0}}) begin
            r_lost_pending <= 1'b1;
            r_overflow     <= 1'b1;
            r_drop_cnt     <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
         end else if (w_n_push != {CW{1'b0}}) begin
            r_lost_pending <= 1'b0;
         end
      end
   end

   commit_trace_fifo #(
      .NPush (NCand),
      .Depth (Depth)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_push_cnt (w_n_push),
      .i_push_rec (w_push_rec),
      .i_pop      (w_pop),
      .o_count    (w_count),
      .o_free     (w_free),
      .o_head     (out_rec_o)
   );

   assign out_valid_o = (w_count != {CW{1'b0}});
   assign drop_cnt_o  = r_drop_cnt;
   assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed testbench for commit_trace_buffer (NrCommitPorts=2, Depth=16).
module tb_commit_trace_buffer;
   import commit_trace_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic                   trace_en;
   logic [1:0]             ack;
   logic [1:0]             drop;
   logic [1:0][VLEN-1:0]   pc;
   logic [1:0][31:0]       instr;
   logic [1:0][4:0]        rd;
   logic [1:0][XLEN-1:0]   wdata;
   logic [1:0]             we_gpr;
   logic [1:0]             we_fpr;
   logic [1:0]             priv;
   logic                   dbg;
   logic                   ex_valid;
   logic [XLEN-1:0]        ex_cause;
   logic [XLEN-1:0]        ex_tval;
   logic                   out_valid;
   logic                   out_ready;
   trace_rec_t             out_rec;
   logic [31:0]            drop_cnt;
   logic                   overflow;

   int n_checks = 0;
   int n_errors = 0;

   commit_trace_buffer #(.NrCommitPorts(2), .Depth(16)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .trace_en_i      (trace_en),
      .commit_ack_i    (ack),
      .commit_drop_i   (drop),
      .commit_pc_i     (pc),
      .commit_instr_i  (instr),
      .commit_rd_i     (rd),
      .commit_wdata_i  (wdata),
      .commit_we_gpr_i (we_gpr),
      .commit_we_fpr_i (we_fpr),
      .priv_lvl_i      (priv),
      .debug_mode_i    (dbg),
      .ex_valid_i      (ex_valid),
      .ex_cause_i      (ex_cause),
      .ex_tval_i       (ex_tval),
      .out_valid_o     (out_valid),
      .out_ready_i     (out_ready),
      .out_rec_o       (out_rec),
      .drop_cnt_o      (drop_cnt),
      .overflow_o      (overflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ack      = 2'b00;
      drop     = 2'b00;
      ex_valid = 1'b0;
      ex_cause = 64'd0;
      ex_tval  = 64'd0;
      dbg      = 1'b0;
   endtask

   task automatic set_port(input int p, input logic [63:0] a);
      ack[p]    = 1'b1;
      pc[p]     = a;
      instr[p]  = 32'h0000_0013 + 32'(p);
      rd[p]     = 5'(p + 1);
      wdata[p]  = 64'hAA + 64'(p);
      we_gpr[p] = 1'b1;
      we_fpr[p] = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      trace_en  = 1'b1;
      pc        = '0;
      instr     = '0;
      rd        = '0;
      wdata     = '0;
      we_gpr    = 2'b00;
      we_fpr    = 2'b00;
      priv      = 2'd3;
      out_ready = 1'b1;
      do_reset();

      // reset state
      check_eq("rst_valid", 64'(out_valid), 64'd0);
      check_eq("rst_drop", 64'(drop_cnt), 64'd0);
      check_eq("rst_ovf", 64'(overflow), 64'd0);
      check_eq("rst_rec", 64'(|out_rec), 64'd0);

      // 1: two retires, drain in consecutive cycles
      set_port(0, 64'h100);
      set_port(1, 64'h104);
      tick();
      idle();
      check_eq("t1_valid0", 64'(out_valid), 64'd1);
      check_eq("t1_seq0", 64'(out_rec.seq), 64'd0);
      check_eq("t1_pc0", out_rec.pc, 64'h100);
      check_eq("t1_rd0", 64'(out_rec.rd), 64'd1);
      check_eq("t1_priv0", 64'(out_rec.priv), 64'd3);
      tick();
      check_eq("t1_seq1", 64'(out_rec.seq), 64'd1);
      check_eq("t1_pc1", out_rec.pc, 64'h104);
      tick();
      check_eq("t1_empty", 64'(out_valid), 64'd0);
      check_eq("t1_drop", 64'(drop_cnt), 64'd0);

      // 2: dropped retire is not recorded; seq unchanged
      set_port(1, 64'h200);
      drop[1] = 1'b1;
      tick();
      idle();
      check_eq("t2_none", 64'(out_valid), 64'd0);
      set_port(0, 64'h208);
      tick();
      idle();
      check_eq("t2_seq", 64'(out_rec.seq), 64'd2);
      tick();

      // 3: overflow with ready low
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 9; c++) begin
         set_port(0, 64'h1000 + 64'(c * 8));
         set_port(1, 64'h1004 + 64'(c * 8));
         tick();
      end
      idle();
      check_eq("t3_drop", 64'(drop_cnt), 64'd2);
      check_eq("t3_ovf", 64'(overflow), 64'd1);
      check_eq("t3_head_stable", out_rec.pc, 64'h1000);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check_eq("t3_drain_seq", 64'(out_rec.seq), 64'(i));
         tick();
      end
      check_eq("t3_empty", 64'(out_valid), 64'd0);
      set_port(0, 64'h3000);
      tick();
      check_eq("t3_next_seq", 64'(out_rec.seq), 64'd16);
      check_eq("t3_next_lost", 64'(out_rec.lost), 64'd1);
      tick();
      idle();
      check_eq("t3_after_seq", 64'(out_rec.seq), 64'd17);
      check_eq("t3_after_lost", 64'(out_rec.lost), 64'd0);
      check_eq("t3_ovf_sticky", 64'(overflow), 64'd1);
      tick();

      // 4: ordering port0, exception, port1
      do_reset();
      out_ready = 1'b0;
      set_port(0, 64'h400);
      set_port(1, 64'h404);
      ex_valid = 1'b1;
      ex_cause = 64'd2;
      ex_tval  = 64'h55;
      tick();
      idle();
      check_eq("t4_i0_exc", 64'(out_rec.is_exc), 64'd0);
      check_eq("t4_i0_pc", out_rec.pc, 64'h400);
      out_ready = 1'b1;
      tick();
      check_eq("t4_ex_exc", 64'(out_rec.is_exc), 64'd1);
      check_eq("t4_ex_pc", out_rec.pc, 64'h400);
      check_eq("t4_ex_cause", out_rec.cause, 64'd2);
      check_eq("t4_ex_tval", out_rec.tval, 64'h55);
      check_eq("t4_ex_rd", 64'(out_rec.rd), 64'd0);
      check_eq("t4_ex_seq", 64'(out_rec.seq), 64'd1);
      tick();
      check_eq("t4_i1_pc", out_rec.pc, 64'h404);
      check_eq("t4_i1_seq", 64'(out_rec.seq), 64'd2);
      tick();
      check_eq("t4_empty", 64'(out_valid), 64'd0);

      // 5: breakpoint in debug mode is filtered
      do_reset();
      ex_valid = 1'b1;
      ex_cause = 64'd3;
      dbg      = 1'b1;
      tick();
      idle();
      check_eq("t5_dbg_none", 64'(out_valid), 64'd0);
      ex_valid = 1'b1;
      ex_cause = 64'd3;
      tick();
      idle();
      check_eq("t5_bp_valid", 64'(out_valid), 64'd1);
      check_eq("t5_bp_cause", out_rec.cause, 64'd3);
      tick();

      // 6a: one slot free, two candidates, pop in the same cycle
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 7; c++) begin
         set_port(0, 64'h5000);
         set_port(1, 64'h5004);
         tick();
      end
      idle();
      set_port(0, 64'h5100);
      tick();
      idle();
      out_ready = 1'b1;
      set_port(0, 64'h600);
      set_port(1, 64'h604);
      tick();
      idle();
      check_eq("t6_drop", 64'(drop_cnt), 64'd1);
      check_eq("t6_ovf", 64'(overflow), 64'd1);
      for (int i = 1; i < 16; i++) begin
         check_eq("t6_drain_seq", 64'(out_rec.seq), 64'(i));
         if (i == 15) begin
            check_eq("t6_last_pc", out_rec.pc, 64'h600);
         end
         tick();
      end
      check_eq("t6_empty", 64'(out_valid), 64'd0);

      // 6b: sequence wrap 0xFFFF -> 0x0000
      do_reset();
      out_ready = 1'b1;
      set_port(0, 64'h700);
      for (int c = 0; c < 65536; c++) begin
         tick();
      end
      check_eq("t6_seq_ffff", 64'(out_rec.seq), 64'hFFFF);
      tick();
      idle();
      check_eq("t6_seq_wrap", 64'(out_rec.seq), 64'h0000);
      tick();

      // 6c: reset during a burst
      out_ready = 1'b0;
      for (int c = 0; c < 9; c++) begin
         set_port(0, 64'h800);
         set_port(1, 64'h804);
         tick();
      end
      check_eq("t6_pre_drop", 64'(drop_cnt), 64'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      check_eq("t6_rst_valid", 64'(out_valid), 64'd0);
      check_eq("t6_rst_drop", 64'(drop_cnt), 64'd0);
      check_eq("t6_rst_ovf", 64'(overflow), 64'd0);
      check_eq("t6_rst_rec", 64'(|out_rec), 64'd0);
      tick();
      check_eq("t6_rst_still", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      set_port(0, 64'h900);
      tick();
      idle();
      check_eq("t6_post_seq", 64'(out_rec.seq), 64'd0);
      check_eq("t6_post_lost", 64'(out_rec.lost), 64'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
